// File: rtl/nap_pkg.sv
// Shared types and constants for the nap countdown timer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package nap_pkg;

    // One BCD digit.
    localparam int DIG_W = 4;

    // Default wrap values: seconds-tens wraps to 5, every other digit to 9.
    localparam logic [DIG_W-1:0] DIG_MAX_DFLT      = 4'd9;
    localparam logic [DIG_W-1:0] SEC_TENS_MAX_DFLT = 4'd5;

    // Width of the post-expiry alarm tick counter (ALARM_TICKS is 1..255).
    localparam int ALARM_CNT_W = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARMED  = 3'd1,
        RUN    = 3'd2,
        PAUSED = 3'd3,
        ALARM  = 3'd4
    } nap_state_t;

    // Saturate a loaded digit to its legal maximum.
    function automatic logic [DIG_W-1:0] clamp_digit(input logic [DIG_W-1:0] d,
                                                      input logic [DIG_W-1:0] lim);
        return (d > lim) ? lim : d;
    endfunction

endpackage

// File: rtl/bcd_digit_dec.sv
// One stage of the BCD borrow chain: decrements a digit when borrow-in is set.
// Latency: combinational, zero cycles.
// Backpressure: none.
//
// Ports:
//   in   [3:0]  current digit value
//   bin         borrow in (decrement request for this digit)
//   max  [3:0]  value the digit wraps to when decremented from 0
//   out  [3:0]  next digit value
//   bout        borrow out to the next more significant digit
module bcd_digit_dec
    import nap_pkg::*;
(
    input  logic [DIG_W-1:0] in,
    input  logic             bin,
    input  logic [DIG_W-1:0] max,
    output logic [DIG_W-1:0] out,
    output logic             bout
);

    always_comb begin
        out  = in;
        bout = 1'b0;
        if (bin) begin
            if (in == '0) begin
                out  = max;
                bout = 1'b1;
            end else begin
                out = in - DIG_W'(1);
            end
        end
    end

endmodule

// File: rtl/nap_countdown.sv
// MM:SS BCD countdown timer with run/pause control and a self-clearing alarm.
// Latency: every output is a flop; an input effect is visible one cycle after the sampling edge.
// Backpressure: none; inputs are level/pulse commands sampled every rising edge.
//
// Ports:
//   clock            system clock, rising edge
//   reset            asynchronous, active-high
//   tick             single-cycle 1 Hz enable
//   load             capture set_min/set_sec (sanitised) into the count
//   set_min/set_sec  BCD {tens,ones} load values
//   start / pause    resume / suspend countdown
//   ack              clear the alarm
//   min / sec        current BCD count
//   running / alarm  high while in RUN / ALARM
module nap_countdown
    import nap_pkg::*;
#(
    parameter int unsigned      ALARM_TICKS  = 10,
    parameter logic [DIG_W-1:0] SEC_TENS_MAX = SEC_TENS_MAX_DFLT,
    parameter logic [DIG_W-1:0] DIG_MAX      = DIG_MAX_DFLT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick,
    input  logic       load,
    input  logic [7:0] set_min,
    input  logic [7:0] set_sec,
    input  logic       start,
    input  logic       pause,
    input  logic       ack,
    output logic [7:0] min,
    output logic [7:0] sec,
    output logic       running,
    output logic       alarm
);

    localparam logic [ALARM_CNT_W-1:0] ALARM_LAST = ALARM_CNT_W'(ALARM_TICKS - 1);

    nap_state_t             state;
    nap_state_t             state_nxt;
    logic [7:0]             min_nxt;
    logic [7:0]             sec_nxt;
    logic [ALARM_CNT_W-1:0] alarm_cnt;
    logic [ALARM_CNT_W-1:0] alarm_cnt_nxt;

    logic [7:0] load_min;
    logic [7:0] load_sec;
    logic       count_nz;

    // Load sanitising: out-of-range digits saturate rather than being rejected.
    assign load_min = {clamp_digit(set_min[7:4], DIG_MAX), clamp_digit(set_min[3:0], DIG_MAX)};
    assign load_sec = {clamp_digit(set_sec[7:4], SEC_TENS_MAX), clamp_digit(set_sec[3:0], DIG_MAX)};
    assign count_nz = (min != 8'h00) || (sec != 8'h00);

    // Borrow chain, least significant digit first. The chain is always
    // evaluated; its result is only used on a RUN tick.
    logic [DIG_W-1:0] so_out, st_out, mo_out, mt_out;
    logic             so_bout, st_bout, mo_bout, mt_bout;
    logic             dec_expire;

    bcd_digit_dec u_sec_ones (
        .in   (sec[3:0]),
        .bin  (1'b1),
        .max  (DIG_MAX),
        .out  (so_out),
        .bout (so_bout)
    );

    bcd_digit_dec u_sec_tens (
        .in   (sec[7:4]),
        .bin  (so_bout),
        .max  (SEC_TENS_MAX),
        .out  (st_out),
        .bout (st_bout)
    );

    bcd_digit_dec u_min_ones (
        .in   (min[3:0]),
        .bin  (st_bout),
        .max  (DIG_MAX),
        .out  (mo_out),
        .bout (mo_bout)
    );

    bcd_digit_dec u_min_tens (
        .in   (min[7:4]),
        .bin  (mo_bout),
        .max  (DIG_MAX),
        .out  (mt_out),
        .bout (mt_bout)
    );

    // Expiry when the decremented value is 00:00. A borrow out of minutes-tens
    // would mean decrementing from 00:00, which RUN never holds; it is folded
    // into expiry so the timer can never wrap to 99:59 and keep running.
    assign dec_expire = ({mt_out, mo_out, st_out, so_out} == 16'h0000) || mt_bout;

    // Commands that have no meaning in the current state are ignored outright
    // rather than masking lower-priority commands (e.g. load in RUN does not
    // block pause, start in RUN does not block tick).
    always_comb begin
        state_nxt     = state;
        min_nxt       = min;
        sec_nxt       = sec;
        alarm_cnt_nxt = alarm_cnt;

        unique case (state)
            IDLE: begin
                if (load) begin
                    min_nxt   = load_min;
                    sec_nxt   = load_sec;
                    state_nxt = ARMED;
                end
            end

            ARMED: begin
                if (load) begin
                    min_nxt = load_min;
                    sec_nxt = load_sec;
                end else if (start && count_nz) begin
                    state_nxt = RUN;
                end
            end

            RUN: begin
                if (pause) begin
                    state_nxt = PAUSED;
                end else if (tick) begin
                    min_nxt = {mt_out, mo_out};
                    sec_nxt = {st_out, so_out};
                    if (dec_expire) begin
                        state_nxt     = ALARM;
                        alarm_cnt_nxt = '0;
                    end
                end
            end

            PAUSED: begin
                if (load) begin
                    min_nxt   = load_min;
                    sec_nxt   = load_sec;
                    state_nxt = ARMED;
                end else if (start) begin
                    state_nxt = RUN;
                end
            end

            ALARM: begin
                if (ack) begin
                    state_nxt     = IDLE;
                    alarm_cnt_nxt = '0;
                end else if (tick) begin
                    if (alarm_cnt == ALARM_LAST) begin
                        state_nxt     = IDLE;
                        alarm_cnt_nxt = '0;
                    end else begin
                        alarm_cnt_nxt = alarm_cnt + ALARM_CNT_W'(1);
                    end
                end
            end

            default: begin
                state_nxt     = IDLE;
                alarm_cnt_nxt = '0;
            end
        endcase
    end

    // running/alarm are registered from the next state so they flip on the
    // same edge as the state register and the count.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            min       <= 8'h00;
            sec       <= 8'h00;
            alarm_cnt <= '0;
            running   <= 1'b0;
            alarm     <= 1'b0;
        end else begin
            state     <= state_nxt;
            min       <= min_nxt;
            sec       <= sec_nxt;
            alarm_cnt <= alarm_cnt_nxt;
            running   <= (state_nxt == RUN);
            alarm     <= (state_nxt == ALARM);
        end
    end

endmodule
